// File: rtl/simt_coalescing_mem_stage.sv
// SIMT coalescing memory stage.
// Takes one warp memory op at a time and checks per-lane alignment. It then
// issues one line request per distinct memory line touched by the active lanes,
// keeping at most one request outstanding, and gathers load data back into
// per-lane results. Non-memory ops pass their ALU result straight through.
module simt_coalescing_mem_stage #(
    parameter int NUM_LANES  = 32,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_is_mem,
    input  logic                        in_is_write,
    input  logic [1:0]                  in_size,
    input  logic                        in_signed,
    input  logic [NUM_LANES-1:0]        in_mask,
    input  logic [NUM_LANES*ADDR_W-1:0] in_addr,
    input  logic [NUM_LANES*DATA_W-1:0] in_wdata,
    input  logic [NUM_LANES*DATA_W-1:0] in_alu,
    output logic                        line_req_valid,
    input  logic                        line_req_ready,
    output logic [ADDR_W-1:0]           line_addr,
    output logic [NUM_LANES-1:0]        line_lane_mask,
    output logic                        line_is_write,
    output logic [1:0]                  line_size,
    output logic [NUM_LANES*ADDR_W-1:0] lane_addr,
    output logic [NUM_LANES*DATA_W-1:0] lane_wdata,
    input  logic                        line_resp_valid,
    input  logic [LINE_BYTES*8-1:0]     line_resp_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*DATA_W-1:0] out_result,
    output logic [NUM_LANES-1:0]        out_fault_mask,
    output logic [$clog2(NUM_LANES):0]  out_req_count
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int CNT_W = $clog2(NUM_LANES) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [NUM_LANES-1:0]        pending_q, pending_d;
    logic [NUM_LANES-1:0]        fault_q, fault_d;
    logic [CNT_W-1:0]            req_count_q, req_count_d;
    logic [NUM_LANES*DATA_W-1:0] result_q, result_d;
    logic                        flush_seen_q, flush_seen_d;
    logic [NUM_LANES*ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_LANES*DATA_W-1:0] wdata_q, wdata_d;
    logic                        is_write_q, is_write_d;
    logic                        signed_q, signed_d;
    logic [1:0]                  size_q, size_d;

    logic                        accept;
    logic                        req_fire;
    logic                        resp_fire;
    logic                        drop_resp;
    logic [NUM_LANES-1:0]        acc_fault;
    logic [NUM_LANES-1:0]        acc_pending;
    logic [NUM_LANES-1:0]        line_match;
    logic [ADDR_W-1:0]           leader_addr;
    logic [OFF_W-1:0]            lane_off;
    logic [DATA_W-1:0]           lane_raw;

    // An access is misaligned when the address is not a multiple of its size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = lo[0];
            default: m = |lo;
        endcase
        return m;
    endfunction

    // Zero- or sign-extend the low byte/half of a lane field; a word fills the lane.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                      input logic [1:0] size,
                                                      input logic sgn);
        logic [DATA_W-1:0] r;
        case (size)
            2'd0:    r = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
            2'd1:    r = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign accept    = (state_q == S_IDLE) && in_valid && !flush;
    assign req_fire  = (state_q == S_ISSUE) && line_req_ready && !flush;
    assign resp_fire = (state_q == S_WAIT) && line_resp_valid;
    assign drop_resp = flush_seen_q || flush;

    // Classify incoming lanes: misaligned active lanes fault and are never requested.
    always_comb begin
        acc_fault = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            acc_fault[i] = in_is_mem && in_mask[i] && misaligned(in_size, in_addr[i*ADDR_W +: 2]);
        end
        acc_pending = in_mask & ~acc_fault;
    end

    // Pick the lowest pending lane as leader and gather every pending lane on its line.
    always_comb begin
        leader_addr = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending_q[i]) leader_addr = addr_q[i*ADDR_W +: ADDR_W];
        end
        line_match = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            line_match[i] = pending_q[i] &&
                (addr_q[i*ADDR_W+OFF_W +: ADDR_W-OFF_W] == leader_addr[ADDR_W-1:OFF_W]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a flush seen during WAIT only takes effect once the response arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = (in_is_mem && (|acc_pending)) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (flush)               state_d = S_IDLE;
                else if (line_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (line_resp_valid) begin
                    if (drop_resp)                      state_d = S_IDLE;
                    else if (|(pending_q & ~line_match)) state_d = S_ISSUE;
                    else                                state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        in_ready       = (state_q == S_IDLE);
        line_req_valid = (state_q == S_ISSUE);
        out_valid      = (state_q == S_DONE);
    end

    // Control and result updates: capture on accept, count requests, merge load data.
    always_comb begin
        pending_d    = pending_q;
        fault_d      = fault_q;
        req_count_d  = req_count_q;
        result_d     = result_q;
        flush_seen_d = 1'b0;
        lane_off     = '0;
        lane_raw     = '0;
        if (accept) begin
            pending_d   = in_is_mem ? acc_pending : '0;
            fault_d     = acc_fault;
            req_count_d = '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                result_d[i*DATA_W +: DATA_W] = (!in_is_mem && in_mask[i]) ?
                                               in_alu[i*DATA_W +: DATA_W] : '0;
            end
        end
        if (req_fire) req_count_d = req_count_q + CNT_W'(1);
        if (state_q == S_WAIT) flush_seen_d = flush_seen_q | flush;
        if (resp_fire) begin
            flush_seen_d = 1'b0;
            pending_d    = pending_q & ~line_match;
            if (!is_write_q && !drop_resp) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (line_match[i]) begin
                        lane_off = addr_q[i*ADDR_W +: OFF_W];
                        lane_raw = DATA_W'(line_resp_data >> {lane_off, 3'b000});
                        result_d[i*DATA_W +: DATA_W] = extend_load(lane_raw, size_q, signed_q);
                    end
                end
            end
        end
        if (state_d == S_IDLE) pending_d = '0;
    end

    // Control and result flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q    <= '0;
            fault_q      <= '0;
            req_count_q  <= '0;
            result_q     <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            fault_q      <= fault_d;
            req_count_q  <= req_count_d;
            result_q     <= result_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // Operand capture for the accepted op.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        signed_d   = signed_q;
        size_d     = size_q;
        if (accept) begin
            addr_d     = in_addr;
            wdata_d    = in_wdata;
            is_write_d = in_is_write;
            signed_d   = in_signed;
            size_d     = in_size;
        end
    end

    // Operand flops; they only matter while an op is in flight.
    always_ff @(posedge clk) begin
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        is_write_q <= is_write_d;
        signed_q   <= signed_d;
        size_q     <= size_d;
    end

    assign line_addr      = leader_addr & ~ADDR_W'(LINE_BYTES - 1);
    assign line_lane_mask = line_match;
    assign line_is_write  = is_write_q;
    assign line_size      = size_q;
    assign lane_addr      = addr_q;
    assign lane_wdata     = wdata_q;
    assign out_result     = result_q;
    assign out_fault_mask = fault_q;
    assign out_req_count  = req_count_q;

endmodule

// File: tb/tb_simt_coalescing_mem_stage.sv
// Directed bench for simt_coalescing_mem_stage with a scoreboard of expected
// line requests and per-op results, and a zero-wait (or delayed) memory model.
`timescale 1ns/1ps
module tb_simt_coalescing_mem_stage;

    localparam int NL = 32;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LB = 64;
    localparam int CW = $clog2(NL) + 1;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, in_is_mem, in_is_write, in_signed;
    logic [1:0]       in_size;
    logic [NL-1:0]    in_mask;
    logic [NL*AW-1:0] in_addr;
    logic [NL*DW-1:0] in_wdata, in_alu;
    logic             line_req_valid, line_req_ready, line_is_write;
    logic [AW-1:0]    line_addr;
    logic [NL-1:0]    line_lane_mask;
    logic [1:0]       line_size;
    logic [NL*AW-1:0] lane_addr;
    logic [NL*DW-1:0] lane_wdata;
    logic             line_resp_valid;
    logic [LB*8-1:0]  line_resp_data;
    logic             out_valid, out_ready;
    logic [NL*DW-1:0] out_result;
    logic [NL-1:0]    out_fault_mask;
    logic [CW-1:0]    out_req_count;

    always #5 clk = ~clk;

    simt_coalescing_mem_stage #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .LINE_BYTES(LB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_mem(in_is_mem), .in_is_write(in_is_write), .in_size(in_size), .in_signed(in_signed),
        .in_mask(in_mask), .in_addr(in_addr), .in_wdata(in_wdata), .in_alu(in_alu),
        .line_req_valid(line_req_valid), .line_req_ready(line_req_ready), .line_addr(line_addr),
        .line_lane_mask(line_lane_mask), .line_is_write(line_is_write), .line_size(line_size),
        .lane_addr(lane_addr), .lane_wdata(lane_wdata), .line_resp_valid(line_resp_valid),
        .line_resp_data(line_resp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_fault_mask(out_fault_mask), .out_req_count(out_req_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [NL-1:0] mask;
    } exp_req_t;

    typedef struct {
        logic [NL*DW-1:0] res;
        logic [NL-1:0]    fault;
        int               count;
    } exp_out_t;

    exp_req_t      req_q[$];
    exp_out_t      out_q[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [AW-1:0] s_addr[NL];
    logic [DW-1:0] s_wdata[NL];
    logic [DW-1:0] s_alu[NL];
    logic          cur_write;
    logic [1:0]    cur_size;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory contents as a function of byte address.
    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        if (a == 32'h2003) return 8'h80;
        return a[7:0] ^ {a[10:8], a[15:11]} ^ 8'hA5;
    endfunction

    function automatic logic [DW-1:0] exp_load(input logic [AW-1:0] a, input logic [1:0] size,
                                               input logic sgn);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem_byte(a);
        b1 = mem_byte(a + 32'd1);
        b2 = mem_byte(a + 32'd2);
        b3 = mem_byte(a + 32'd3);
        case (size)
            2'd0:    return (sgn && b0[7]) ? {24'hFFFFFF, b0} : {24'h0, b0};
            2'd1:    return (sgn && b1[7]) ? {16'hFFFF, b1, b0} : {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic logic misal(input logic [1:0] size, input logic [1:0] lo);
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return lo[0];
        return |lo;
    endfunction

    // Build expectations for the op in s_* and drive it for one accept cycle.
    task automatic issue_op(input logic is_mem, input logic is_write, input logic [1:0] size,
                            input logic sgn, input logic [NL-1:0] mask);
        exp_out_t      eo;
        exp_req_t      er;
        logic [AW-1:0] lines[$];
        logic [NL-1:0] lmask[$];
        int            found;
        eo.fault = '0;
        eo.res   = '0;
        eo.count = 0;
        for (int i = 0; i < NL; i++) begin
            if (is_mem && mask[i] && misal(size, s_addr[i][1:0])) eo.fault[i] = 1'b1;
        end
        // Lines ordered by the lowest lane index that touches them.
        if (is_mem) begin
            for (int i = 0; i < NL; i++) begin
                if (mask[i] && !eo.fault[i]) begin
                    found = -1;
                    for (int j = 0; j < lines.size(); j++)
                        if (lines[j] == (s_addr[i] & ~32'(LB - 1))) found = j;
                    if (found < 0) begin
                        lines.push_back(s_addr[i] & ~32'(LB - 1));
                        lmask.push_back(NL'(1) << i);
                    end else begin
                        lmask[found][i] = 1'b1;
                    end
                end
            end
        end
        for (int j = 0; j < lines.size(); j++) begin
            er.addr = lines[j];
            er.mask = lmask[j];
            req_q.push_back(er);
        end
        eo.count = lines.size();
        for (int i = 0; i < NL; i++) begin
            if (!mask[i])                   eo.res[i*DW +: DW] = '0;
            else if (!is_mem)               eo.res[i*DW +: DW] = s_alu[i];
            else if (eo.fault[i] || is_write) eo.res[i*DW +: DW] = '0;
            else                            eo.res[i*DW +: DW] = exp_load(s_addr[i], size, sgn);
        end
        out_q.push_back(eo);
        cur_write   = is_write;
        cur_size    = size;
        in_valid    = 1'b1;
        in_is_mem   = is_mem;
        in_is_write = is_write;
        in_size     = size;
        in_signed   = sgn;
        in_mask     = mask;
        for (int i = 0; i < NL; i++) begin
            in_addr[i*AW +: AW]  = s_addr[i];
            in_wdata[i*DW +: DW] = s_wdata[i];
            in_alu[i*DW +: DW]   = s_alu[i];
        end
        chk("in_ready_at_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [AW-1:0] la);
        logic [LB*8-1:0] ld;
        for (int k = 0; k < LB; k++) ld[k*8 +: 8] = mem_byte(la + AW'(k));
        line_resp_data  = ld;
        line_resp_valid = 1'b1;
        @(posedge clk); #1;
        line_resp_valid = 1'b0;
    endtask

    // Serve line requests and collect the result of the op just issued.
    task automatic run_op(input int ready_delay);
        exp_out_t      eo;
        exp_req_t      er;
        logic [AW-1:0] la;
        int            c, nreq;
        bit            got;
        c = 0; nreq = 0; got = 0;
        while (!got && c < 400) begin
            if (out_valid) begin
                eo = out_q.pop_front();
                for (int i = 0; i < NL; i++)
                    chk($sformatf("result[%0d]", i), out_result[i*DW +: DW], eo.res[i*DW +: DW]);
                chk("fault_mask", out_fault_mask, eo.fault);
                chk("out_req_count", out_req_count, eo.count);
                chk("num_handshakes", nreq, eo.count);
                if (ready_delay == 0) chk("latency", c, 2 * eo.count);
                chk("in_ready_in_done", in_ready, 0);
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                chk("out_valid_after_pop", out_valid, 0);
                chk("in_ready_after_pop", in_ready, 1);
                got = 1;
            end else if (line_req_valid) begin
                chk("req_expected", req_q.size() > 0, 1);
                if (req_q.size() > 0) er = req_q.pop_front();
                else                  er = '{default: '0};
                chk("line_addr", line_addr, er.addr);
                chk("line_lane_mask", line_lane_mask, er.mask);
                chk("line_is_write", line_is_write, cur_write);
                chk("line_size", line_size, cur_size);
                for (int d = 0; d < ready_delay; d++) begin
                    line_resp_valid = 1'b1;
                    line_resp_data  = '1;
                    @(posedge clk); #1;
                    c++;
                    chk("stall_valid", line_req_valid, 1);
                    chk("stall_addr", line_addr, er.addr);
                    chk("stall_mask", line_lane_mask, er.mask);
                end
                line_resp_valid = 1'b0;
                line_req_ready  = 1'b1;
                la = line_addr;
                @(posedge clk); #1;
                c++;
                line_req_ready = 1'b0;
                nreq++;
                chk("no_req_in_wait", line_req_valid, 0);
                send_resp(la);
                c++;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        if (!got) chk("out_valid_timeout", got, 1);
    endtask

    task automatic wait_req();
        int c;
        c = 0;
        while (!line_req_valid && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("req_seen", line_req_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_out_t eo;
        exp_req_t er;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_is_mem = 1'b0; in_is_write = 1'b0;
        in_size = 2'd0; in_signed = 1'b0; in_mask = '0; in_addr = '0; in_wdata = '0; in_alu = '0;
        line_req_ready = 1'b0; line_resp_valid = 1'b0; line_resp_data = '0; out_ready = 1'b0;
        for (int i = 0; i < NL; i++) begin s_addr[i] = '0; s_wdata[i] = '0; s_alu[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_line_req_valid", line_req_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_req_count", out_req_count, 0);
        chk("reset_result_nonzero", |out_result, 0);
        chk("reset_fault", out_fault_mask, 0);

        // Unit-stride word loads over two lines.
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h1000 + 32'(4 * i);
        issue_op(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF);
        run_op(0);

        // Broadcast signed byte load.
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h2003;
        issue_op(1'b1, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF);
        run_op(0);

        // Half loads with one misaligned lane.
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h3000 + 32'(2 * i);
        s_addr[5] = 32'h3001;
        issue_op(1'b1, 1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF);
        run_op(0);

        // Non-memory pass-through.
        for (int i = 0; i < NL; i++) s_alu[i] = 32'(i);
        issue_op(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF);
        run_op(0);

        // Stalled request with stray responses while it waits.
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h6000 + 32'(2 * i);
        issue_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_F0F0);
        run_op(5);

        // Strided stores, alternate lanes.
        for (int i = 0; i < NL; i++) begin
            s_addr[i]  = 32'h7000 + 32'(8 * i);
            s_wdata[i] = 32'h1111_1111 * 32'(i);
        end
        issue_op(1'b1, 1'b1, 2'd2, 1'b0, 32'hAAAA_AAAA);
        chk("lane_wdata3", lane_wdata[3*DW +: DW], s_wdata[3]);
        chk("lane_addr3", lane_addr[3*AW +: AW], s_addr[3]);
        run_op(0);

        // Every active lane misaligned: no requests at all.
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h7101 + 32'(4 * i);
        issue_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h00FF_00FF);
        run_op(0);

        // Random signed byte gather and unsigned half gather.
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h8000 + 32'($urandom_range(0, 255));
        issue_op(1'b1, 1'b0, 2'd0, 1'b1, 32'($urandom));
        run_op(0);
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h9000 + 32'(2 * $urandom_range(0, 95));
        issue_op(1'b1, 1'b0, 2'd1, 1'b0, 32'($urandom));
        run_op(0);

        // Non-memory op with inactive lanes.
        for (int i = 0; i < NL; i++) s_alu[i] = 32'($urandom);
        issue_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0F0F_0F0F);
        run_op(0);

        // Flush during WAIT of a 4-line gather.
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h4000 + 32'(64 * (i % 4)) + 32'(4 * (i / 4));
        issue_op(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF);
        wait_req();
        er = req_q.pop_front();
        chk("flush_line_addr", line_addr, er.addr);
        chk("flush_line_mask", line_lane_mask, er.mask);
        line_req_ready = 1'b1;
        @(posedge clk); #1;
        line_req_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_still_waiting", in_ready, 0);
        send_resp(er.addr);
        for (int k = 0; k < 6; k++) begin
            chk("flush_no_req", line_req_valid, 0);
            chk("flush_no_out", out_valid, 0);
            chk("flush_idle", in_ready, 1);
            @(posedge clk); #1;
        end
        req_q.delete();
        eo = out_q.pop_back();

        // Flush while holding a finished result.
        for (int i = 0; i < NL; i++) s_alu[i] = 32'hA0 + 32'(i);
        issue_op(1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF);
        chk("done_before_flush", out_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_out_valid", out_valid, 0);
        chk("flush_done_in_ready", in_ready, 1);
        eo = out_q.pop_back();

        // Reset in WAIT, then a late response.
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h5000 + 32'(4 * i);
        issue_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_00FF);
        wait_req();
        line_req_ready = 1'b1;
        @(posedge clk); #1;
        line_req_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_wait_req_count", out_req_count, 0);
        send_resp(32'h5000);
        for (int k = 0; k < 3; k++) begin
            chk("rst_wait_no_out", out_valid, 0);
            chk("rst_wait_no_req", line_req_valid, 0);
            chk("rst_wait_in_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        req_q.delete();
        eo = out_q.pop_back();

        // The stage still works after the abandoned op.
        for (int i = 0; i < NL; i++) s_addr[i] = 32'h2000 + 32'(4 * i);
        issue_op(1'b1, 1'b0, 2'd2, 1'b1, 32'hFFFF_0001);
        run_op(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/simt_coalescing_mem_stage.md
SIMT_COALESCING_MEM_STAGE -- requirements
Module: simt_coalescing_mem_stage

Interface
REQ-001 SHALL have parameter NUM_LANES, default 32, lanes per warp (power of 2, 4..64).
REQ-002 SHALL have parameter DATA_W, default 32, lane data width.
REQ-003 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-004 SHALL have parameter LINE_BYTES, default 64, memory line size (power of 2, >= DATA_W/8).
REQ-005 SHALL use one clock; reset is synchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  abandon current warp op
- in_valid / in_ready  in/out  1  warp op handshake
- in_is_mem  in  1  op accesses memory
- in_is_write  in  1  store (else load)
- in_size  in  2  0 byte, 1 half, 2 word
- in_signed  in  1  sign-extend loads
- in_mask  in  NUM_LANES  active lanes
- in_addr  in  NUM_LANES*ADDR_W  per-lane byte address
- in_wdata  in  NUM_LANES*DATA_W  per-lane store data
- in_alu  in  NUM_LANES*DATA_W  pass-through result
- line_req_valid / line_req_ready  out/in  1  line request handshake
- line_addr  out  ADDR_W  line-aligned address
- line_lane_mask  out  NUM_LANES  lanes served by this request
- line_is_write / line_size  out  1 / 2  access type
- lane_addr / lane_wdata  out  NUM_LANES*ADDR_W / *DATA_W  registered per-lane address/data
- line_resp_valid  in  1  response for the outstanding request
- line_resp_data  in  LINE_BYTES*8  line read data, byte 0 at LSB
- out_valid / out_ready  out/in  1  result handshake
- out_result  out  NUM_LANES*DATA_W  per-lane result
- out_fault_mask  out  NUM_LANES  misaligned lanes
- out_req_count  out  $clog2(NUM_LANES)+1  line requests issued for this op

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, DONE; in_ready = (state==IDLE).
REQ-007 On in_valid&&in_ready SHALL register all inputs; pending = in_mask & ~fault; next state ISSUE if in_is_mem and pending!=0, else DONE.
REQ-008 Lane fault SHALL be set when active and addr not aligned to size (half: bit0; word: bits1:0); faulted lanes are never requested; their result is 0.
REQ-009 In ISSUE: leader = lowest-index set bit of pending; line_addr = leader addr with low log2(LINE_BYTES) bits cleared; line_lane_mask = pending lanes whose addr>>log2(LINE_BYTES) matches leader's; line_req_valid=1.
REQ-010 line_req_valid/line_addr/line_lane_mask SHALL hold stable until line_req_ready; on handshake go WAIT and increment out_req_count (saturation not required, max NUM_LANES).
REQ-011 Only one request outstanding; line_resp_valid outside WAIT SHALL be ignored.
REQ-012 In WAIT on line_resp_valid: for loads, each masked lane captures the size-wide field at byte offset addr[log2(LINE_BYTES)-1:0], zero- or sign-extended per in_signed; pending &= ~line_lane_mask; next ISSUE if pending!=0 else DONE.
REQ-013 Stores SHALL produce result 0 for memory lanes; non-mem ops SHALL output in_alu unchanged with out_req_count 0.
REQ-014 In DONE out_valid=1, outputs stable until out_ready; on out_ready go IDLE, same cycle in_ready stays 0 (next accept earliest one cycle later).
REQ-015 Latency: non-mem op accepted cycle N -> out_valid cycle N+1; mem op with K lines, zero-wait memory -> out_valid at N+1+2K.
REQ-016 Inactive lanes SHALL output 0.
REQ-017 flush in IDLE/ISSUE/DONE SHALL force IDLE next cycle with out_valid and line_req_valid low; flush in WAIT SHALL be latched, response consumed and discarded, then IDLE (no further requests).
REQ-018 Simultaneous flush and out_ready in DONE: go IDLE, no special behaviour.

Reset
REQ-019 While rst_n=0 at a clk edge: state IDLE, pending 0, flush latch 0, out_req_count 0, results 0, out_valid 0, line_req_valid 0, in_ready 1 after reset released.
REQ-020 Reset mid-WAIT SHALL abandon the request; a late line_resp_valid after reset is ignored.

Verification
REQ-021 Unit-stride LW, 32 lanes, addr=0x1000+4*i, LINE_BYTES 64 -> 2 requests (0x1000 mask 0x0000FFFF, 0x1040 mask 0xFFFF0000), out_req_count 2.
REQ-022 Broadcast LB signed, all lanes addr 0x2003, line byte3=0x80 -> 1 request, all results 0xFFFFFF80.
REQ-023 LH lane 5 addr 0x3001, others aligned same line -> out_fault_mask 0x20, lane5 result 0, 1 request excluding lane5.
REQ-024 Non-mem op, in_alu lane i = i -> out_valid next cycle, results 0..31, no line_req_valid.
REQ-025 Flush during WAIT of a 4-line gather -> response accepted, no further requests, IDLE, no out_valid.
REQ-026 line_req_ready held low 5 cycles -> line_addr/mask stable throughout, single count.
